mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port Start, input, 1, E-stage request strobe: operation in MdOp is valid this cycle.
REQ-004 SHALL have port MdOp, input, 3, operation code:
- 0 none
- 1 mult
- 2 multu
- 3 div
- 4 divu
- 5 mthi
- 6 mtlo
REQ-005 SHALL have port SrcA, input, 32, forwarded rs value from E stage.
REQ-006 SHALL have port SrcB, input, 32, forwarded rt value from E stage.
REQ-007 SHALL have port Busy, output, 1, registered: an operation is in flight.
REQ-008 SHALL have port HI, output, 32, committed HI register, readable by mfhi.
REQ-009 SHALL have port LO, output, 32, committed LO register, readable by mflo.

Function
REQ-010 SHALL sample Start and MdOp only on a rising clk edge; Start with MdOp=0 SHALL be a no-op.
REQ-011 SHALL ignore Start entirely while Busy=1: no state change and no queueing; the hazard unit guarantees this never happens legally.
REQ-012 On accepted mult or multu, SHALL compute the 64-bit product of SrcA and SrcB, signed or unsigned respectively, at the Start edge and hold it in a pending register.
REQ-013 On accepted div or divu, SHALL compute quotient (pending LO) and remainder (pending HI) at the Start edge, signed or unsigned respectively.
REQ-014 Signed div SHALL truncate the quotient toward zero; the remainder SHALL take the sign of the dividend.
REQ-015 At the Start edge, SHALL load the latency counter with 5 for mult/multu or 10 for div/divu, and SHALL set Busy=1 at the same edge.
REQ-016 While counter>1, each edge SHALL decrement the counter with HI/LO unchanged.
REQ-017 At the edge where counter==1:
- counter SHALL go to 0
- Busy SHALL go to 0
- pending HI/LO SHALL commit to HI/LO
REQ-018 Net timing: Busy SHALL be high for exactly 5 (mult) or 10 (div) cycles, and new HI/LO SHALL be visible in the first cycle Busy=0.
REQ-019 Division by zero (SrcB=0, div or divu) SHALL run full latency with Busy behaving normally, then leave HI and LO unchanged.
REQ-020 mthi/mtlo SHALL write SrcA to HI or LO respectively at the Start edge, with Busy staying 0 and no latency.
REQ-021 HI/LO outputs SHALL show the previously committed values throughout Busy.
REQ-022 Counter SHALL be 4 bits wide; it SHALL never wrap, and it SHALL rest at 0 when idle.

Reset
REQ-023 reset SHALL be synchronous, active-high, and take priority over Start.
REQ-024 On reset, SHALL set HI=0, LO=0, Busy=0, counter=0, pending HI=0 and pending LO=0.
REQ-025 Reset mid-operation SHALL abort the operation: the pending result is discarded and never committed.

Structure
REQ-026 MdOp encodings 0-6 and latency constants MULT_CYCLES=5 and DIV_CYCLES=10 SHALL be defined in the shared constants.v include.
REQ-027 SHALL be a single module with no sub-module; the E-stage top instantiates it next to the ALU and feeds Busy plus Start to the hazard unit for D-stage stall of HI/LO-touching instructions.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Signed mult: mult, SrcA=0xFFFFFFFF, SrcB=0x00000002 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- Unsigned mult: multu, same operands -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- Signed div: div, SrcA=0xFFFFFFF9 (-7), SrcB=2 -> Busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero: divu with SrcB=0 after mthi 0x12345678 -> Busy high 10 cycles; HI stays 0x12345678.
- Start while busy: mult, then Start with mtlo 0xAAAAAAAA at Busy cycle 2 -> LO equals the mult result only, with no 0xAAAAAAAA.
- Reset mid-operation: mult started, reset asserted at Busy cycle 3 -> next cycle Busy=0, HI=LO=0, and no commit afterwards.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: opcode encodings and
// the fixed latencies seen by the hazard unit.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MdNone  = 3'd0,
        MdMult  = 3'd1,
        MdMultu = 3'd2,
        MdDiv   = 3'd3,
        MdDivu  = 3'd4,
        MdMthi  = 3'd5,
        MdMtlo  = 3'd6
    } md_op_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } md_state_e;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: the result is computed at the Start edge and
// held pending, then committed to HI/LO after a fixed multi-cycle latency.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MdOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

    logic        accept, long_op;
    logic [63:0] prod_s, prod_u;
    logic        div_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, q_res, r_res;

    assign accept  = Start && (state_q == StIdle);
    assign long_op = (MdOp == MdMult) || (MdOp == MdMultu) ||
                     (MdOp == MdDiv)  || (MdOp == MdDivu);

    assign prod_s = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
    assign prod_u = {32'd0, SrcA} * {32'd0, SrcB};

    // Signed divide on magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend; also keeps -2^31 / -1 well defined.
    assign div_signed = (MdOp == MdDiv);
    assign a_neg      = div_signed && SrcA[31];
    assign b_neg      = div_signed && SrcB[31];
    assign a_mag      = a_neg ? (~SrcA + 32'd1) : SrcA;
    assign b_mag      = b_neg ? (~SrcB + 32'd1) : SrcB;
    assign q_mag      = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
    assign r_mag      = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
    assign q_res      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign r_res      = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept && long_op) state_d = StBusy;
            StBusy: if (cnt_q <= 4'd1)     state_d = StIdle;
            default:                       state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        if (accept) begin
            case (MdOp)
                MdMult: begin
                    {pend_hi_d, pend_lo_d} = prod_s;
                    cnt_d = MULT_CYCLES;
                end
                MdMultu: begin
                    {pend_hi_d, pend_lo_d} = prod_u;
                    cnt_d = MULT_CYCLES;
                end
                MdDiv, MdDivu: begin
                    // Divide by zero commits the current HI/LO back unchanged.
                    if (SrcB != 32'd0) begin
                        pend_hi_d = r_res;
                        pend_lo_d = q_res;
                    end else begin
                        pend_hi_d = hi_q;
                        pend_lo_d = lo_q;
                    end
                    cnt_d = DIV_CYCLES;
                end
                MdMthi:  hi_d = SrcA;
                MdMtlo:  lo_d = SrcA;
                default: ;
            endcase
        end else if (state_q == StBusy) begin
            if (cnt_q > 4'd1) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                cnt_d = 4'd0;
                hi_d  = pend_hi_q;
                lo_d  = pend_lo_q;
            end
        end
    end

    always_comb begin
        Busy = (state_q == StBusy);
        HI   = hi_q;
        LO   = lo_q;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a reference model pushes the expected
// HI/LO and latency at issue; they are popped when Busy drops.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MdOp;
    logic [31:0] SrcA, SrcB;
    logic        Busy;
    logic [31:0] HI, LO;

    exp_t        sb[$];
    logic [31:0] m_hi, m_lo, old_hi, old_lo;
    int          n_checks = 0;
    int          n_fails  = 0;

    mult_div_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MdOp  (MdOp),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] hi,
                                   input logic [31:0] lo);
        exp_t        e;
        longint      ps;
        logic [63:0] pu;
        int          sa, sb_v;
        e.hi = hi; e.lo = lo; e.lat = 0;
        sa = a; sb_v = b;
        case (op)
            MdMult: begin
                ps = longint'(sa) * longint'(sb_v);
                e.hi = ps[63:32]; e.lo = ps[31:0]; e.lat = 5;
            end
            MdMultu: begin
                pu = {32'd0, a} * {32'd0, b};
                e.hi = pu[63:32]; e.lo = pu[31:0]; e.lat = 5;
            end
            MdDiv: begin
                if (b != 0) begin e.lo = sa / sb_v; e.hi = sa % sb_v; end
                e.lat = 10;
            end
            MdDivu: begin
                if (b != 0) begin e.lo = a / b; e.hi = a % b; end
                e.lat = 10;
            end
            MdMthi: e.hi = a;
            MdMtlo: e.lo = a;
            default: ;
        endcase
        return e;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        old_hi = m_hi; old_lo = m_lo;
        e = model(op, a, b, m_hi, m_lo);
        sb.push_back(e);
        m_hi = e.hi; m_lo = e.lo;
        @(negedge clk);
        Start = 1'b1; MdOp = op; SrcA = a; SrcB = b;
        @(negedge clk);
        Start = 1'b0; MdOp = MdNone;
    endtask

    // inj_cycle > 0 drives an illegal mtlo 0xAAAAAAAA at that Busy cycle.
    task automatic wait_done(input int inj_cycle);
        exp_t e;
        int   lat = 0;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        while (Busy && lat < 20) begin
            lat++;
            check_eq("hold_hi", HI, old_hi);
            check_eq("hold_lo", LO, old_lo);
            if (lat == inj_cycle) begin
                Start = 1'b1; MdOp = MdMtlo; SrcA = 32'hAAAA_AAAA;
            end else begin
                Start = 1'b0; MdOp = MdNone;
            end
            @(negedge clk);
        end
        Start = 1'b0; MdOp = MdNone;
        check_eq("latency", lat, e.lat);
        check_eq("hi", HI, e.hi);
        check_eq("lo", LO, e.lo);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        reset = 1'b1; Start = 1'b0; MdOp = MdNone; SrcA = '0; SrcB = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", Busy, 1'b0);
        check_eq("rst_hi", HI, 32'd0);
        check_eq("rst_lo", LO, 32'd0);
        reset = 1'b0;

        issue(MdMult, 32'hFFFF_FFFF, 32'h0000_0002);  wait_done(0);
        issue(MdMultu, 32'hFFFF_FFFF, 32'h0000_0002); wait_done(0);
        issue(MdDiv, 32'hFFFF_FFF9, 32'h0000_0002);   wait_done(0);
        issue(MdMthi, 32'h1234_5678, 32'h0);          wait_done(0);
        issue(MdDivu, 32'hDEAD_BEEF, 32'h0);          wait_done(0);
        check_eq("div0_hi", HI, 32'h1234_5678);

        // Start with opcode none is a no-op.
        issue(MdNone, 32'h5555_5555, 32'h1);          wait_done(0);

        // Illegal Start while busy must be dropped.
        issue(MdMult, 32'h0000_0003, 32'h0000_0007);  wait_done(2);
        check_eq("no_mtlo", LO, 32'd21);

        // Reset at Busy cycle 3 aborts the pending result.
        issue(MdMult, 32'h0001_0000, 32'h0001_0000);
        void'(sb.pop_back());
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_busy", Busy, 1'b0);
        check_eq("abort_hi", HI, 32'd0);
        check_eq("abort_lo", LO, 32'd0);
        repeat (8) @(negedge clk);
        check_eq("abort_late_hi", HI, 32'd0);
        check_eq("abort_late_lo", LO, 32'd0);
        check_eq("abort_late_busy", Busy, 1'b0);

        for (int i = 0; i < 12; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            b  = (i % 5 == 4) ? 32'd0 : $urandom;
            if (op == MdDiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            issue(op, a, b);
            wait_done(0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
